// File: rtl/dct_coef_sequencer.sv
// dct_coef_sequencer: produces one 2-D 8x8 DCT coefficient.
// The block sweeps the 64 pixel addresses and steers the cos-term LUT bank so
// that its indices always match the pixel currently on pix_data. It accumulates
// (pixel-128)*cos_term and returns acc >>> FRAC_BITS over a valid/ready handshake.
module dct_coef_sequencer #(
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       k1_in,
    input  logic [2:0]       k2_in,
    output logic [5:0]       pix_addr,
    input  logic [7:0]       pix_data,
    output logic [2:0]       lut_k1,
    output logic [2:0]       lut_k2,
    output logic [2:0]       lut_n1,
    output logic [2:0]       lut_n2,
    input  logic [31:0]      cos_term,
    output logic [ACC_W-1:0] coef,
    output logic             coef_valid,
    input  logic             coef_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [5:0]              pix_addr_q, pix_addr_d;   // doubles as the sweep index
    logic [5:0]              lut_n_q, lut_n_d;         // pix_addr delayed to match pix_data
    logic [2:0]              lut_k1_q, lut_k1_d;
    logic [2:0]              lut_k2_q, lut_k2_d;
    logic                    acc_en_q, acc_en_d;       // pix_data/cos_term pair is live
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] coef_q, coef_d;
    logic                    coef_valid_q, coef_valid_d;

    logic signed [8:0]       pix_diff;
    logic signed [ACC_W-1:0] pix_ext, cos_ext, prod, acc_sum;

    // Multiply-accumulate datapath. Only the low ACC_W bits are kept, so the sum wraps.
    always_comb begin
        pix_diff = $signed({1'b0, pix_data}) - 9'sd128;
        pix_ext  = ACC_W'(pix_diff);
        cos_ext  = ACC_W'($signed(cos_term));
        prod     = pix_ext * cos_ext;
        acc_sum  = acc_q + prod;
    end

    // Next-state and register updates. Abort overrides every other decision.
    always_comb begin
        state_d      = state_q;
        pix_addr_d   = pix_addr_q;
        lut_n_d      = lut_n_q;
        lut_k1_d     = lut_k1_q;
        lut_k2_d     = lut_k2_q;
        acc_en_d     = (state_q == RUN);
        acc_d        = acc_en_q ? acc_sum : acc_q;
        coef_d       = coef_q;
        coef_valid_d = coef_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    lut_k1_d   = k1_in;
                    lut_k2_d   = k2_in;
                    acc_d      = '0;
                    pix_addr_d = 6'd0;
                end
            end
            RUN: begin
                lut_n_d = pix_addr_q;
                if (pix_addr_q == 6'd63) begin
                    state_d = DRAIN;
                end else begin
                    pix_addr_d = pix_addr_q + 6'd1;
                end
            end
            DRAIN: begin
                // The last sample is still in flight, so the result comes from acc_sum.
                state_d      = DONE;
                coef_d       = acc_sum >>> FRAC_BITS;
                coef_valid_d = 1'b1;
            end
            DONE: begin
                if (coef_valid_q && coef_ready) begin
                    state_d      = IDLE;
                    coef_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d      = IDLE;
            pix_addr_d   = pix_addr_q;
            lut_n_d      = lut_n_q;
            lut_k1_d     = lut_k1_q;
            lut_k2_d     = lut_k2_q;
            acc_d        = '0;
            acc_en_d     = 1'b0;
            coef_d       = coef_q;
            coef_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset clears everything, so no partial result survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_addr_q   <= '0;
            lut_n_q      <= '0;
            lut_k1_q     <= '0;
            lut_k2_q     <= '0;
            acc_en_q     <= 1'b0;
            acc_q        <= '0;
            coef_q       <= '0;
            coef_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_addr_q   <= pix_addr_d;
            lut_n_q      <= lut_n_d;
            lut_k1_q     <= lut_k1_d;
            lut_k2_q     <= lut_k2_d;
            acc_en_q     <= acc_en_d;
            acc_q        <= acc_d;
            coef_q       <= coef_d;
            coef_valid_q <= coef_valid_d;
        end
    end

    assign pix_addr   = pix_addr_q;
    assign lut_k1     = lut_k1_q;
    assign lut_k2     = lut_k2_q;
    assign lut_n1     = lut_n_q[5:3];
    assign lut_n2     = lut_n_q[2:0];
    assign coef       = coef_q;
    assign coef_valid = coef_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dct_coef_sequencer.sv
// Bench for dct_coef_sequencer. A pixel RAM and a cos LUT bank are modelled around
// the DUT. Expected coefficients go into a queue and a monitor checks each handshake.
module tb_dct_coef_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        coef_ready = 1'b0;
    logic [2:0]  k1_in = '0;
    logic [2:0]  k2_in = '0;
    logic [5:0]  pix_addr;
    logic [7:0]  pix_data = '0;
    logic [2:0]  lut_k1, lut_k2, lut_n1, lut_n2;
    logic [31:0] cos_term;
    logic [31:0] coef;
    logic        coef_valid;
    logic        busy;

    int mem[64];
    int lut_tab[4096];
    int exp_q[$];
    int total = 0;
    int bad = 0;

    dct_coef_sequencer #(.ACC_W(32), .FRAC_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .k1_in(k1_in), .k2_in(k2_in), .pix_addr(pix_addr), .pix_data(pix_data),
        .lut_k1(lut_k1), .lut_k2(lut_k2), .lut_n1(lut_n1), .lut_n2(lut_n2),
        .cos_term(cos_term), .coef(coef), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // 1-cycle block RAM and combinational LUT bank
    always @(posedge clk) pix_data <= 8'(mem[pix_addr]);
    assign cos_term = lut_tab[{lut_k1, lut_k2, lut_n1, lut_n2}];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain sum over the block, wrapped to 32 bits, then arithmetic shift.
    function automatic int model(input int a, input int b);
        longint s = 0;
        for (int n = 0; n < 64; n++)
            s += (longint'(mem[n]) - 128) * longint'(lut_tab[a*512 + b*64 + n]);
        return int'(s) >>> 8;
    endfunction

    // Monitor: compares on handshake, checks hold stability, flags spurious valids.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_coef = '0;
    always @(negedge clk) begin
        if (coef_valid && !prev_valid && exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL valid_unexpected: coef_valid=1 coef=%0d with nothing expected", $signed(coef));
        end
        if (coef_valid && prev_valid && !prev_ready)
            chk("coef_hold", $signed(coef), $signed(prev_coef));
        if (coef_valid && coef_ready && exp_q.size() != 0)
            chk("coef", $signed(coef), exp_q.pop_front());
        prev_valid = coef_valid;
        prev_ready = coef_ready;
        prev_coef  = coef;
    end

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 64; i++) mem[i] = (mode == 0) ? 128 : int'($urandom_range(0, 255));
    endtask

    task automatic fill_lut(input int mode);
        for (int i = 0; i < 4096; i++)
            lut_tab[i] = (mode == 0) ? int'($urandom_range(0, 1200)) - 600 : int'($urandom());
    endtask

    task automatic launch(input int a, input int b, input bit push, input int expv);
        k1_in = a[2:0];
        k2_in = b[2:0];
        start = 1'b1;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walks the sweep from the start edge: address order, LUT lag, latency.
    task automatic follow();
        int errs = 0;
        int lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c < 64 && pix_addr != 6'(c)) errs++;
            if (c > 0 && c <= 64 && {lut_n1, lut_n2} != 6'(c - 1)) errs++;
            if (coef_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
        end
        chk("addr_lut_seq_errs", errs, 0);
        chk("latency", lat, 65);
    endtask

    task automatic finish_run(input int d);
        if (!coef_ready) begin
            repeat (d) @(posedge clk);
            #1 coef_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_after_handshake", busy, 0);
    endtask

    initial begin
        int errs;
        fill_mem(0);
        fill_lut(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {pix_addr, lut_k1, lut_k2, lut_n1, lut_n2, coef_valid, busy}, 0);
        chk("reset_coef", coef, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flat block -> zero coefficient
        coef_ready = 1'b1;
        launch(4, 5, 1, 0);
        follow();
        finish_run(1);

        // single bright pixel
        fill_mem(0);
        mem[1] = 255;
        lut_tab[{3'd0, 3'd1, 3'd0, 3'd1}] = -177;
        launch(0, 1, 1, -88);
        follow();
        finish_run(1);

        // single dark pixel
        fill_mem(0);
        mem[0] = 0;
        lut_tab[{3'd0, 3'd0, 3'd0, 3'd0}] = 100;
        launch(0, 0, 1, -50);
        follow();
        finish_run(1);

        // backpressure with ignored start pulses, then start held across the handshake
        fill_mem(1);
        coef_ready = 1'b0;
        launch(2, 3, 1, model(2, 3));
        follow();
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 start = 1'($urandom_range(0, 1));
            k1_in = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (!(busy && coef_valid)) errs++;
        end
        chk("hold_busy_valid_errs", errs, 0);
        @(posedge clk);
        #1 coef_ready = 1'b1;
        start = 1'b1;
        k1_in = 3'd6;
        k2_in = 3'd7;
        @(posedge clk);
        #1 exp_q.push_back(model(6, 7));
        @(negedge clk);
        chk("idle_after_hs_start_ignored", busy, 0);
        @(posedge clk);
        #1 start = 1'b0;
        follow();
        finish_run(1);

        // abort mid-sweep, then a clean run
        fill_mem(1);
        launch(1, 6, 0, 0);
        repeat (30) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", coef_valid, 0);
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("abort_no_valid_later", {busy, coef_valid}, 0);
        @(posedge clk);
        #1;
        launch(1, 6, 1, model(1, 6));
        follow();
        finish_run(1);

        // reset mid-sweep, then the bright-pixel case again
        fill_mem(0);
        mem[1] = 255;
        lut_tab[{3'd0, 3'd1, 3'd0, 3'd1}] = -177;
        launch(0, 1, 0, 0);
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {pix_addr, lut_k1, lut_k2, lut_n1, lut_n2, coef_valid, busy}, 0);
        chk("midreset_coef", coef, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(0, 1, 1, -88);
        follow();
        finish_run(1);

        // random blocks, random LUTs (last one full-range to exercise wrap), random ready
        for (int r = 0; r < 6; r++) begin
            int a, b;
            fill_mem(1);
            fill_lut(r == 5 ? 1 : 0);
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            coef_ready = 1'($urandom_range(0, 1));
            launch(a, b, 1, model(a, b));
            follow();
            finish_run(int'($urandom_range(1, 5)));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
